// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, ALU opcode and shift-type encodings for the execute stage
package ex_stage_pkg;

  localparam int WORD_WIDTH            = 32;
  localparam int REG_FILE_DEPTH        = 4;
  localparam int SIGNED_IMM_WIDTH      = 24;
  localparam int SHIFTER_OPERAND_WIDTH = 12;

  typedef enum logic [3:0] {
    EX_MOV = 4'b0001,
    EX_ADD = 4'b0010,
    EX_ADC = 4'b0011,
    EX_SUB = 4'b0100,
    EX_SBC = 4'b0101,
    EX_AND = 4'b0110,
    EX_ORR = 4'b0111,
    EX_EOR = 4'b1000,
    EX_MVN = 4'b1001
  } ex_cmd_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Shift by (32 - n) is out of range when n == 0 and yields 0, so no special case is needed.
  function automatic logic [WORD_WIDTH-1:0] ror32(input logic [WORD_WIDTH-1:0] x,
                                                  input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/ex_stage_val2_generator.sv
// rtl/ex_stage_val2_generator.sv - second ALU operand: rotated immediate, memory offset or shifted Rm
module val2_generator
  import ex_stage_pkg::*;
(
  input  logic [WORD_WIDTH-1:0]            val_rm,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand,
  input  logic                             imm,
  input  logic                             mem_access,
  output logic [WORD_WIDTH-1:0]            val2
);

  logic [4:0] shift_amt;
  assign shift_amt = shifter_operand[11:7];

  always_comb begin
    val2 = '0;
    if (imm) begin
      val2 = ror32({{(WORD_WIDTH-8){1'b0}}, shifter_operand[7:0]}, {shifter_operand[11:8], 1'b0});
    end else if (mem_access) begin
      val2 = {{(WORD_WIDTH-SHIFTER_OPERAND_WIDTH){1'b0}}, shifter_operand};
    end else begin
      case (shift_e'(shifter_operand[6:5]))
        SHIFT_LSL: val2 = val_rm << shift_amt;
        SHIFT_LSR: val2 = val_rm >> shift_amt;
        SHIFT_ASR: val2 = $unsigned($signed(val_rm) >>> shift_amt);
        default:   val2 = ror32(val_rm, shift_amt);
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: val2, ALU, flags, branch target and EX/MEM register
// Optional operand forwarding muxes are enabled by defining FORWARDING_EN.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
`ifdef FORWARDING_EN
  input  logic [1:0]                       sel_src1,
  input  logic [1:0]                       sel_src2,
  input  logic [WORD_WIDTH-1:0]            mem_fwd_val,
  input  logic [WORD_WIDTH-1:0]            wb_fwd_val,
`endif
  input  logic                             freeze,
  input  logic [WORD_WIDTH-1:0]            pc_in,
  input  logic [WORD_WIDTH-1:0]            val_Rn_in,
  input  logic [WORD_WIDTH-1:0]            val_Rm_in,
  input  logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate_in,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in,
  input  logic [3:0]                       EX_command_in,
  input  logic [REG_FILE_DEPTH-1:0]        reg_file_dst_in,
  input  logic                             mem_read_in,
  input  logic                             mem_write_in,
  input  logic                             WB_en_in,
  input  logic                             Imm_in,
  input  logic                             B_in,
  input  logic                             SR_update_in,
  output logic [WORD_WIDTH-1:0]            alu_result,
  output logic [WORD_WIDTH-1:0]            st_val,
  output logic [REG_FILE_DEPTH-1:0]        dst_out,
  output logic                             mem_read_out,
  output logic                             mem_write_out,
  output logic                             WB_en_out,
  output logic                             branch_taken,
  output logic [WORD_WIDTH-1:0]            branch_addr,
  output logic [3:0]                       status_register
);

  logic [WORD_WIDTH-1:0] op1;
  logic [WORD_WIDTH-1:0] rm_val;
  logic [WORD_WIDTH-1:0] val2;
  logic [WORD_WIDTH-1:0] alu_res;
  logic [WORD_WIDTH:0]   arith_sum;
  logic                  is_arith;
  logic                  is_sub;
  logic                  cmd_valid;
  flags_t                sr_q;
  flags_t                flags_next;

`ifdef FORWARDING_EN
  always_comb begin
    case (sel_src1)
      2'd1:    op1 = mem_fwd_val;
      2'd2:    op1 = wb_fwd_val;
      default: op1 = val_Rn_in;
    endcase
    case (sel_src2)
      2'd1:    rm_val = mem_fwd_val;
      2'd2:    rm_val = wb_fwd_val;
      default: rm_val = val_Rm_in;
    endcase
  end
`else
  assign op1    = val_Rn_in;
  assign rm_val = val_Rm_in;
`endif

  val2_generator u_val2 (
    .val_rm          (rm_val),
    .shifter_operand (shifter_operand_in),
    .imm             (Imm_in),
    .mem_access      (mem_read_in | mem_write_in),
    .val2            (val2)
  );

  // Subtraction is op1 + ~val2 + carry-in, so the 33rd bit is the ARM "not borrow" carry.
  always_comb begin
    alu_res   = '0;
    arith_sum = '0;
    is_arith  = 1'b0;
    is_sub    = 1'b0;
    cmd_valid = 1'b1;
    case (ex_cmd_e'(EX_command_in))
      EX_MOV: alu_res = val2;
      EX_MVN: alu_res = ~val2;
      EX_ADD: begin
        is_arith  = 1'b1;
        arith_sum = {1'b0, op1} + {1'b0, val2};
      end
      EX_ADC: begin
        is_arith  = 1'b1;
        arith_sum = {1'b0, op1} + {1'b0, val2} + {{WORD_WIDTH{1'b0}}, sr_q.c};
      end
      EX_SUB: begin
        is_arith  = 1'b1;
        is_sub    = 1'b1;
        arith_sum = {1'b0, op1} + {1'b0, ~val2} + {{WORD_WIDTH{1'b0}}, 1'b1};
      end
      EX_SBC: begin
        is_arith  = 1'b1;
        is_sub    = 1'b1;
        arith_sum = {1'b0, op1} + {1'b0, ~val2} + {{WORD_WIDTH{1'b0}}, sr_q.c};
      end
      EX_AND: alu_res = op1 & val2;
      EX_ORR: alu_res = op1 | val2;
      EX_EOR: alu_res = op1 ^ val2;
      default: cmd_valid = 1'b0;
    endcase
    if (is_arith) alu_res = arith_sum[WORD_WIDTH-1:0];

    flags_next = sr_q;
    if (cmd_valid) begin
      flags_next.n = alu_res[WORD_WIDTH-1];
      flags_next.z = (alu_res == '0);
      if (is_arith) begin
        flags_next.c = arith_sum[WORD_WIDTH];
        flags_next.v = is_sub
          ? ((op1[WORD_WIDTH-1] != val2[WORD_WIDTH-1]) && (alu_res[WORD_WIDTH-1] != op1[WORD_WIDTH-1]))
          : ((op1[WORD_WIDTH-1] == val2[WORD_WIDTH-1]) && (alu_res[WORD_WIDTH-1] != op1[WORD_WIDTH-1]));
      end
    end
  end

  assign branch_taken = B_in;
  assign branch_addr  = pc_in + {{(WORD_WIDTH-SIGNED_IMM_WIDTH-2){signed_immediate_in[SIGNED_IMM_WIDTH-1]}},
                                 signed_immediate_in, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result    <= '0;
      st_val        <= '0;
      dst_out       <= '0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      WB_en_out     <= 1'b0;
    end else if (!freeze) begin
      alu_result    <= alu_res;
      st_val        <= rm_val;
      dst_out       <= reg_file_dst_in;
      mem_read_out  <= mem_read_in;
      mem_write_out <= mem_write_in;
      WB_en_out     <= WB_en_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (!freeze && SR_update_in) begin
      sr_q <= flags_next;
    end
  end

  assign status_register = sr_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed vector table, freeze/reset sequences and randomized model check of ex_stage
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [31:0] pc_in, val_Rn_in, val_Rm_in;
  logic [23:0] signed_immediate_in;
  logic [11:0] shifter_operand_in;
  logic [3:0]  EX_command_in, reg_file_dst_in;
  logic        mem_read_in, mem_write_in, WB_en_in, Imm_in, B_in, SR_update_in;
  logic [31:0] alu_result, st_val, branch_addr;
  logic [3:0]  dst_out, status_register;
  logic        mem_read_out, mem_write_out, WB_en_out, branch_taken;
`ifdef FORWARDING_EN
  logic [1:0]  sel_src1 = 2'd0, sel_src2 = 2'd0;
  logic [31:0] mem_fwd_val = 32'd0, wb_fwd_val = 32'd0;
`endif

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst),
`ifdef FORWARDING_EN
    .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
`endif
    .freeze(freeze), .pc_in(pc_in), .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in),
    .signed_immediate_in(signed_immediate_in), .shifter_operand_in(shifter_operand_in),
    .EX_command_in(EX_command_in), .reg_file_dst_in(reg_file_dst_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .WB_en_in(WB_en_in),
    .Imm_in(Imm_in), .B_in(B_in), .SR_update_in(SR_update_in),
    .alu_result(alu_result), .st_val(st_val), .dst_out(dst_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .WB_en_out(WB_en_out),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .status_register(status_register)
  );

  int checks = 0;
  int failures = 0;

  // Expected registered state, maintained by the bench
  logic [31:0] exp_res = '0, exp_st = '0;
  logic [3:0]  exp_dst = '0, exp_flags = '0;
  logic [2:0]  exp_ctl = '0;

  typedef struct {
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] so;
    logic [3:0]  cmd;
    logic        imm;
    logic        mem_rd;
    logic        sr;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t tbl[10];

  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".alu_result"}, alu_result, exp_res);
    chk({tag, ".status"}, {28'd0, status_register}, {28'd0, exp_flags});
    chk({tag, ".st_val"}, st_val, exp_st);
    chk({tag, ".dst_ctl"}, {25'd0, dst_out, mem_read_out, mem_write_out, WB_en_out},
        {25'd0, exp_dst, exp_ctl});
  endtask

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
    return x;
  endfunction

  function automatic logic [31:0] m_val2(input logic [31:0] rm, input logic [11:0] so,
                                         input logic imm, input logic mem);
    logic [31:0] x;
    int amt;
    if (imm) return m_rotr({24'd0, so[7:0]}, 2 * int'(so[11:8]));
    if (mem) return {20'd0, so};
    amt = int'(so[11:7]);
    x = rm;
    case (so[6:5])
      2'd0: for (int i = 0; i < amt; i++) x = x * 2;
      2'd1: for (int i = 0; i < amt; i++) x = x / 2;
      2'd2: for (int i = 0; i < amt; i++) x = {x[31], x[31:1]};
      default: x = m_rotr(x, amt);
    endcase
    return x;
  endfunction

  // Arithmetic in 64-bit integers: carry = unsigned range exceeded / no borrow, overflow = signed range exceeded
  task automatic m_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] cmd,
                       input logic [3:0] fin, output logic [31:0] res, output logic [3:0] fout);
    longint ua, ub, sa, sb, full, sfull;
    logic c_in, carry, ovf, ar;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c_in = fin[1]; ar = 1'b1; full = 0; sfull = 0; carry = 1'b0; res = '0;
    case (cmd)
      4'd2: begin full = ua + ub; sfull = sa + sb; carry = full > 64'hFFFFFFFF; end
      4'd3: begin full = ua + ub + c_in; sfull = sa + sb + c_in; carry = full > 64'hFFFFFFFF; end
      4'd4: begin full = ua - ub; sfull = sa - sb; carry = ua >= ub; end
      4'd5: begin
        full = ua - ub - (c_in ? 0 : 1); sfull = sa - sb - (c_in ? 0 : 1);
        carry = ua >= ub + (c_in ? 0 : 1);
      end
      default: ar = 1'b0;
    endcase
    ovf = (sfull > SMAX) || (sfull < SMIN);
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: if (ar) res = full[31:0];
    endcase
    if (cmd == 4'd0 || cmd > 4'd9) fout = fin;
    else fout = {res[31], res == 32'd0, ar ? carry : fin[1], ar ? ovf : fin[0]};
  endtask

  task automatic drive(input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so,
                       input logic [3:0] cmd, input logic imm, input logic rd, input logic wr,
                       input logic wb, input logic sr, input logic [3:0] dst);
    val_Rn_in = rn; val_Rm_in = rm; shifter_operand_in = so; EX_command_in = cmd;
    Imm_in = imm; mem_read_in = rd; mem_write_in = wr; WB_en_in = wb;
    SR_update_in = sr; reg_file_dst_in = dst;
  endtask

  function automatic logic [31:0] pick_word();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] v2, r, bexp;
    logic [3:0]  f;
    logic [11:0] so;
    logic        rd, wr, fz;
    longint      t;

    tbl[0] = '{32'h7FFFFFFF, 32'd1,        12'h000, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h80000000, 4'b1001};
    tbl[1] = '{32'd5,        32'd0,        12'h005, 4'b0100, 1'b1, 1'b0, 1'b1, 32'h00000000, 4'b0110};
    tbl[2] = '{32'd1,        32'd1,        12'h000, 4'b0011, 1'b0, 1'b0, 1'b1, 32'h00000003, 4'b0000};
    tbl[3] = '{32'd0,        32'd0,        12'h4FF, 4'b0001, 1'b1, 1'b0, 1'b1, 32'hFF000000, 4'b1000};
    tbl[4] = '{32'd0,        32'h80000000, 12'h240, 4'b0001, 1'b0, 1'b0, 1'b1, 32'hF8000000, 4'b1000};
    tbl[5] = '{32'd0,        32'd0,        12'h000, 4'b0101, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1000};
    tbl[6] = '{32'h1234,     32'h5678,     12'h000, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h00000000, 4'b1000};
    tbl[7] = '{32'h00F0,     32'h000F,     12'h000, 4'b0110, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b1000};
    tbl[8] = '{32'hFF00,     32'h0F0F,     12'h000, 4'b1000, 1'b0, 1'b0, 1'b1, 32'h0000F00F, 4'b0000};
    tbl[9] = '{32'h1000,     32'd0,        12'hABC, 4'b0010, 1'b0, 1'b1, 1'b0, 32'h00001ABC, 4'b0000};

    rst = 1'b1; freeze = 1'b0; pc_in = '0; signed_immediate_in = '0; B_in = 1'b0;
    drive(32'hDEAD, 32'hBEEF, 12'h0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rn, tbl[i].rm, tbl[i].so, tbl[i].cmd, tbl[i].imm, tbl[i].mem_rd, 1'b0,
            i[0], tbl[i].sr, i[3:0]);
      exp_res = tbl[i].res; exp_flags = tbl[i].flags; exp_st = tbl[i].rm;
      exp_dst = i[3:0]; exp_ctl = {tbl[i].mem_rd, 1'b0, i[0]};
      @(posedge clk);
      #1;
      chk_regs($sformatf("vec%0d", i));
    end

    // Branch target is combinational
    B_in = 1'b1; pc_in = 32'h100; signed_immediate_in = 24'hFFFFFE;
    #1;
    chk("branch_taken", {31'd0, branch_taken}, 32'd1);
    chk("branch_addr_back", branch_addr, 32'h000000F8);

    // Freeze holds everything while inputs change; branch path stays live
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(32'h7FFFFFFF, 32'h7FFFFFFF, 12'h000, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7 + 4'(i));
      pc_in = 32'h200 + 32'(i * 16); signed_immediate_in = 24'd1; B_in = i[0];
      #1;
      chk("freeze.branch_addr", branch_addr, 32'h204 + 32'(i * 16));
      chk("freeze.branch_taken", {31'd0, branch_taken}, {31'd0, i[0]});
      @(posedge clk);
      #1;
      chk_regs($sformatf("freeze%0d", i));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_res = '0; exp_st = '0; exp_dst = '0; exp_ctl = '0; exp_flags = '0;
    chk_regs("rst_freeze");
    rst = 1'b0; freeze = 1'b0;

    // An instruction in flight when reset arrives is discarded
    drive(32'd2, 32'd3, 12'h000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h4);
    @(posedge clk);
    #1;
    exp_res = 32'd5; exp_st = 32'd3; exp_dst = 4'h4; exp_ctl = 3'b001;
    chk_regs("pre_reset_op");
    drive(32'hFFFFFFFF, 32'd1, 12'h000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_res = '0; exp_st = '0; exp_dst = '0; exp_ctl = '0; exp_flags = '0;
    chk_regs("mid_op_reset");
    rst = 1'b0;

    for (int n = 0; n < 300; n++) begin
      so = 12'($urandom);
      rd = ($urandom_range(0, 5) == 0);
      wr = !rd && ($urandom_range(0, 5) == 0);
      fz = ($urandom_range(0, 4) == 0);
      drive(pick_word(), pick_word(), so, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            rd, wr, 1'($urandom), 1'($urandom), 4'($urandom));
      freeze = fz;
      pc_in = $urandom; signed_immediate_in = 24'($urandom); B_in = 1'($urandom);
      #1;
      t = longint'(pc_in) + 4 * longint'($signed(signed_immediate_in));
      bexp = t[31:0];
      chk("rand.branch_addr", branch_addr, bexp);
      chk("rand.branch_taken", {31'd0, branch_taken}, {31'd0, B_in});
      v2 = m_val2(val_Rm_in, so, Imm_in, rd | wr);
      m_alu(val_Rn_in, v2, EX_command_in, exp_flags, r, f);
      if (!fz) begin
        exp_res = r; exp_st = val_Rm_in; exp_dst = reg_file_dst_in;
        exp_ctl = {rd, wr, WB_en_in};
        if (SR_update_in) exp_flags = f;
      end
      @(posedge clk);
      #1;
      chk_regs($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
